// File: rtl/spi_master.sv
// spi_master -- single-slave SPI master, mode 0 (SCLK idles low, MOSI changes
// on falling edges, both ends sample on rising edges), MSB first.
//
// Bytes are accepted through a valid/ready handshake. tx_last marks the final
// byte of a message: after it, ss_n is held low for one further SCLK half
// period, then released for one more half period before the next message can
// start. Without tx_last the master parks in WAIT with ss_n low and SCLK idle
// until the next byte is offered.
//
// Parameter:
//   CLK_DIV   SCLK half-period in clk cycles (2..255)
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous active-low reset
//   tx_valid  tx_data/tx_last are offered
//   tx_data   byte to transmit (MSB first)
//   tx_last   byte ends the message
//   tx_ready  byte accepted where tx_valid && tx_ready (IDLE or WAIT only)
//   miso      serial data from the slave
//   sclk      SPI clock (registered)
//   mosi      serial data to the slave (registered)
//   ss_n      slave select, active low (registered)
//   done      one-cycle pulse when a byte completes (registered)
//   rx_data   byte received on miso, valid with done
//
// Build option:
//   SPI_MISO_EN  when defined, miso is captured on SCLK rising edges and
//                presented on rx_data; otherwise rx_data is constant 0.

module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss_n,
    output logic       done,
    output logic [7:0] rx_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    logic [2:0] r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_last;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_ss_n;
    logic       r_fin;
    logic       r_done;

    logic       w_ready;
    logic       w_hs;
    logic       w_div_end;
    logic [7:0] w_rx_data;

    assign w_ready   = (r_state == S_IDLE) || (r_state == S_WAIT);
    assign w_hs      = tx_valid && w_ready;
    assign w_div_end = (r_div == DIV_MAX);

    assign tx_ready = w_ready;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;
    assign done     = r_done;
    assign rx_data  = w_rx_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_last  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_fin   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // r_fin marks the last falling edge; done follows one cycle later
            // so that rx_data and done update together.
            r_fin  <= 1'b0;
            r_done <= r_fin;

            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (w_hs) begin
                        r_shift <= tx_data;
                        r_mosi  <= tx_data[7];
                        r_last  <= tx_last;
                        r_ss_n  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        if (r_sclk) begin
                            // Falling edge: either the byte is finished or
                            // the next bit goes out on mosi.
                            if (r_bit == 3'd7) begin
                                r_bit   <= '0;
                                r_fin   <= 1'b1;
                                r_state <= r_last ? S_HOLD : S_WAIT;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_mosi  <= r_shift[6];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_ss_n  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_GAP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_mosi  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MISO_EN
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_data;

    // miso is taken in the first clk cycle of each SCLK high phase; the slave
    // only changes it after the following falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            if ((r_state == S_SHIFT) && r_sclk && (r_div == '0)) begin
                r_rx_shift <= {r_rx_shift[6:0], miso};
            end
            if (r_fin) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign w_rx_data = r_rx_data;
`else
    logic w_unused_miso;

    assign w_unused_miso = miso;
    assign w_rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master with CLK_DIV=4. A behavioural SPI slave
// drives miso and collects mosi bytes; expected edge times, done pulses and
// received bytes are computed from the protocol timing rules.

module tb_spi_master;

    localparam int D = 4;

    typedef int iq_t[$];

    logic       clk;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       done;
    logic [7:0] rx_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    iq_t rise_q, fall_q, done_q, rx_q, mosi_q, ssnr_q, ssnf_q;

    logic [7:0] slv_bytes [64];
    logic [7:0] msg [8];
    int         slv_idx = 0;
    int         slv_bit = 0;
    int         eidx    = 0;

    // monitor state
    logic       prev_sclk = 1'b0;
    logic       prev_ssn  = 1'b1;
    logic [7:0] mon_sr    = '0;
    int         mon_bc    = 0;
    logic [7:0] slv_cur;

    spi_master #(.CLK_DIV(D)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .miso     (miso),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .done     (done),
        .rx_data  (rx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input iq_t o, input iq_t e);
        check({tag, "_count"}, o.size(), e.size());
        for (int i = 0; i < o.size() && i < e.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), o[i], e[i]);
        end
    endtask

    // Slave model and monitor, evaluated away from the active edge.
    initial begin
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (sclk && !prev_sclk) begin
                rise_q.push_back(cyc);
                if (!ss_n) begin
                    mon_sr = {mon_sr[6:0], mosi};
                    mon_bc++;
                    if (mon_bc == 8) begin
                        mosi_q.push_back(int'(mon_sr));
                        mon_bc = 0;
                    end
                end
            end
            if (!sclk && prev_sclk) begin
                fall_q.push_back(cyc);
                if (!ss_n) begin
                    slv_bit++;
                    if (slv_bit == 8) begin
                        slv_bit = 0;
                        slv_idx++;
                    end
                end
            end
            if (ss_n && !prev_ssn) ssnr_q.push_back(cyc);
            if (!ss_n && prev_ssn) ssnf_q.push_back(cyc);
            if (ss_n) begin
                mon_bc  = 0;
                slv_bit = 0;
            end
            if (done) begin
                done_q.push_back(cyc);
                rx_q.push_back(int'(rx_data));
            end
            slv_cur   = slv_bytes[slv_idx % 64];
            miso      = slv_cur[3'(7 - slv_bit)];
            prev_sclk = sclk;
            prev_ssn  = ss_n;
        end
    end

    task automatic clear_mon();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
        rx_q.delete();
        mosi_q.delete();
        ssnr_q.delete();
        ssnf_q.delete();
    endtask

    // Called just after a negedge; returns the cycle where tx_ready is first seen.
    task automatic wait_ready(output int c, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (tx_ready !== 1'b1) begin
            tx_data = 8'($urandom);
            tx_last = 1'($urandom);
            @(negedge clk);
            n++;
            if (n > 40 * D + 100) begin
                ok = 1'b0;
                break;
            end
        end
        c = cyc;
    endtask

    task automatic run_msg(input int n, input int stall);
        int  h [8];
        int  rc;
        int  bad;
        bit  ok;
        iq_t er, ef, ed, erx, em, esf, esr;
        clear_mon();
        for (int i = 0; i < n; i++) begin
            wait_ready(rc, ok);
            if (!ok) begin
                check("ready_timeout", 0, 1);
                return;
            end
            if (i > 0) check("wait_ready_cyc", rc, h[i-1] + 1 + 16 * D);
            if (i > 0 && stall > 0) begin
                bad = 0;
                for (int s = 0; s < stall; s++) begin
                    if (sclk !== 1'b0 || ss_n !== 1'b0 || tx_ready !== 1'b1) bad++;
                    tx_data = 8'($urandom);
                    @(negedge clk);
                end
                check("wait_stall", bad, 0);
            end
            h[i]     = cyc;
            tx_valid = 1'b1;
            tx_data  = msg[i];
            tx_last  = (i == n - 1);
            @(negedge clk);
            tx_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                er.push_back(h[i] + 1 + D + 2 * D * k);
                ef.push_back(h[i] + 1 + 2 * D + 2 * D * k);
            end
            ed.push_back(h[i] + 2 + 16 * D);
            em.push_back(int'(msg[i]));
`ifdef SPI_MISO_EN
            erx.push_back(int'(slv_bytes[eidx % 64]));
`else
            erx.push_back(0);
`endif
            eidx++;
        end
        wait_ready(rc, ok);
        if (!ok) begin
            check("idle_timeout", 0, 1);
            return;
        end
        check("idle_ready_cyc", rc, h[n-1] + 1 + 18 * D);
        esf.push_back(h[0] + 1);
        esr.push_back(h[n-1] + 1 + 17 * D);
        cmp_q("sclk_rise", rise_q, er);
        cmp_q("sclk_fall", fall_q, ef);
        cmp_q("done", done_q, ed);
        cmp_q("rx_data", rx_q, erx);
        cmp_q("mosi_byte", mosi_q, em);
        cmp_q("ssn_fall", ssnf_q, esf);
        cmp_q("ssn_rise", ssnr_q, esr);
    endtask

    task automatic reset_mid_byte();
        int n = 0;
        int r0;
        clear_mon();
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        tx_last  = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        while (rise_q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_third_rise", rise_q.size(), 3);
        #2 reset = 1'b0;
        #1;
        check("rst_sclk", sclk, 1'b0);
        check("rst_ss_n", ss_n, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", tx_ready, 1'b1);
        r0 = rise_q.size();
        repeat (20 * D) @(negedge clk);
        check("rst_no_done", done_q.size(), 0);
        check("rst_no_sclk", rise_q.size(), r0);
        check("rst_ss_n_idle", ss_n, 1'b1);
        check("rst_ready_idle", tx_ready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int stall;
        for (int i = 0; i < 64; i++) slv_bytes[i] = 8'($urandom);
        slv_bytes[0] = 8'h96;
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sclk", sclk, 1'b0);
        check("reset_mosi", mosi, 1'b0);
        check("reset_ss_n", ss_n, 1'b1);
        check("reset_done", done, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("reset_ready", tx_ready, 1'b1);

        msg[0] = 8'hA5;
        run_msg(1, 0);

        msg[0] = 8'h3C;
        msg[1] = 8'hFF;
        run_msg(2, 0);

        msg[0] = 8'($urandom);
        msg[1] = 8'($urandom);
        run_msg(2, 50);

        msg[0] = 8'h00;
        msg[1] = 8'h5A;
        msg[2] = 8'hFF;
        run_msg(3, 0);

        reset_mid_byte();

        for (int m = 0; m < 6; m++) begin
            n     = $urandom_range(1, 4);
            stall = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
            run_msg(n, stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
